// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 icode/stat constants and SEQ sequencer state type
package y86_pkg;
  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] ICMOVXX = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef enum logic [3:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEMORY,
    ST_WRITEBACK, ST_PCUPD, ST_HALTED, ST_FAULT
  } seq_state_t;

  function automatic logic is_mem_op(input logic [3:0] ic);
    return ic inside {IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ};
  endfunction
endpackage

// File: rtl/y86_pc_sel.sv
// rtl/y86_pc_sel.sv - combinational new-PC select (call/taken jump/ret/fall-through)
module y86_pc_sel
  import y86_pkg::*;
(
  input  logic [3:0]  icode,
  input  logic        cnd,
  input  logic [63:0] valC,
  input  logic [63:0] valP,
  input  logic [63:0] valM,
  output logic [63:0] new_pc
);
  always_comb begin
    new_pc = valP;
    if (icode == ICALL || (icode == IJXX && cnd)) new_pc = valC;
    else if (icode == IRET)                      new_pc = valM;
  end
endmodule

// File: rtl/y86_seq_ctrl.sv
// rtl/y86_seq_ctrl.sv - multi-cycle SEQ Y86-64 sequencer: PC, stage strobes, status, counters
module y86_seq_ctrl
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [63:0]      PC,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imm_err,
  input  logic             hlt,
  input  logic [63:0]      valC,
  input  logic [63:0]      valP,
  input  logic             cnd,
  input  logic [63:0]      valM,
  input  logic             mem_ready,
  input  logic             dmem_err,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             exec_en,
  output logic             mem_en,
  output logic             wb_en,
  output logic [2:0]       stat,
  output logic             busy,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] cycles
);
  seq_state_t  state, state_nxt;
  logic [3:0]  q_icode;
  logic [63:0] q_valC, q_valP, q_valM;
  logic        q_cnd;
  logic [63:0] new_pc;

  y86_pc_sel u_pc_sel (
    .icode  (q_icode),
    .cnd    (q_cnd),
    .valC   (q_valC),
    .valP   (q_valP),
    .valM   (q_valM),
    .new_pc (new_pc)
  );

  always_comb begin
    state_nxt = state;
    fetch_en  = 1'b0;
    decode_en = 1'b0;
    exec_en   = 1'b0;
    mem_en    = 1'b0;
    wb_en     = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        fetch_en = 1'b1;
        if (imm_err || !instr_valid) state_nxt = ST_FAULT;
        else if (hlt)                state_nxt = ST_HALTED;
        else                         state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        decode_en = 1'b1;
        state_nxt = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        exec_en   = 1'b1;
        state_nxt = is_mem_op(q_icode) ? ST_MEMORY : ST_WRITEBACK;
      end
      ST_MEMORY: begin
        mem_en = 1'b1;
        if (mem_ready) state_nxt = dmem_err ? ST_FAULT : ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        wb_en     = 1'b1;
        state_nxt = ST_PCUPD;
      end
      ST_PCUPD: state_nxt = ST_FETCH;
      default:  busy = 1'b0;
    endcase
  end

  // HALTED/FAULT fall into the default arms below, so PC/stat/counters freeze there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      PC      <= RESET_PC;
      stat    <= SAOK;
      retired <= '0;
      cycles  <= '0;
      q_icode <= '0;
      q_valC  <= '0;
      q_valP  <= '0;
      q_valM  <= '0;
      q_cnd   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (busy) cycles <= cycles + CNT_W'(1);
      case (state)
        ST_FETCH: begin
          q_icode <= icode;
          q_valC  <= valC;
          q_valP  <= valP;
          if (imm_err)           stat <= SADR;
          else if (!instr_valid) stat <= SINS;
          else if (hlt) begin
            stat    <= SHLT;
            retired <= retired + CNT_W'(1);
          end
        end
        ST_EXECUTE: q_cnd <= cnd;
        ST_MEMORY: begin
          if (mem_ready) begin
            q_valM <= valM;
            if (dmem_err) stat <= SADR;
          end
        end
        ST_PCUPD: begin
          PC      <= new_pc;
          retired <= retired + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_y86_seq_ctrl.sv
// tb/tb_y86_seq_ctrl.sv - scoreboard bench for y86_seq_ctrl with an instruction-level reference model
module tb_y86_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [63:0] PC;
  logic [3:0]  icode;
  logic        instr_valid, imm_err, hlt, cnd, mem_ready, dmem_err;
  logic [63:0] valC, valP, valM;
  logic        fetch_en, decode_en, exec_en, mem_en, wb_en, busy;
  logic [2:0]  stat;
  logic [31:0] retired, cycles;
  logic [4:0]  strobes;

  always #5 clk = ~clk;
  assign strobes = {fetch_en, decode_en, exec_en, mem_en, wb_en};

  y86_seq_ctrl #(.RESET_PC(64'd0), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .PC(PC),
    .icode(icode), .instr_valid(instr_valid), .imm_err(imm_err), .hlt(hlt),
    .valC(valC), .valP(valP), .cnd(cnd), .valM(valM),
    .mem_ready(mem_ready), .dmem_err(dmem_err),
    .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en),
    .mem_en(mem_en), .wb_en(wb_en), .stat(stat), .busy(busy),
    .retired(retired), .cycles(cycles)
  );

  typedef struct {
    logic [3:0]  icode;
    logic [63:0] valC, valP, valM;
    logic        cnd, instr_valid, imm_err, hlt, dmem_err;
    int          wait_n;
  } instr_t;

  typedef struct {
    logic [63:0] pc;
    int          lat, mem_cyc, wb_cyc;
    logic [2:0]  stat;
    logic [31:0] retired, cycles;
  } exp_t;

  instr_t      prog[$];
  exp_t        exp_q[$];
  exp_t        last_e;
  int          n_cmp = 0, n_bad = 0;
  logic [63:0] m_pc;
  logic [31:0] m_ret, m_cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic bit is_mem(input logic [3:0] ic);
    return ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  endfunction

  function automatic logic [63:0] next_pc(input instr_t t);
    case (t.icode)
      4'h8:    return t.valC;
      4'h7:    return t.cnd ? t.valC : t.valP;
      4'h9:    return t.valM;
      default: return t.valP;
    endcase
  endfunction

  // kind: 0 completes normally, 1 stops at fetch, 2 faults in memory
  task automatic model(input instr_t t, output exp_t e, output int kind);
    e.pc = m_pc; e.mem_cyc = 0; e.wb_cyc = 0; e.stat = 3'd1; kind = 0;
    if (t.imm_err) begin e.stat = 3'd3; e.lat = 1; kind = 1; end
    else if (!t.instr_valid) begin e.stat = 3'd4; e.lat = 1; kind = 1; end
    else if (t.hlt) begin e.stat = 3'd2; e.lat = 1; kind = 1; m_ret++; end
    else begin
      if (is_mem(t.icode)) e.mem_cyc = t.wait_n + 1;
      if (is_mem(t.icode) && t.dmem_err) begin
        e.stat = 3'd3; e.lat = 3 + e.mem_cyc; kind = 2;
      end else begin
        e.lat = 5 + e.mem_cyc; e.wb_cyc = 1; m_ret++; m_pc = next_pc(t);
      end
    end
    m_cyc += e.lat;
    e.retired = m_ret;
    e.cycles  = m_cyc;
  endtask

  function automatic instr_t mk(input logic [3:0] ic, input logic [63:0] c, input logic [63:0] p,
                                input logic [63:0] m, input logic cd, input int w);
    instr_t t;
    t.icode = ic; t.valC = c; t.valP = p; t.valM = m; t.cnd = cd; t.wait_n = w;
    t.instr_valid = 1'b1; t.imm_err = 1'b0; t.hlt = 1'b0; t.dmem_err = 1'b0;
    return t;
  endfunction

  function automatic instr_t mk_rand();
    return mk(4'($urandom_range(1, 11)), {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom}, 1'($urandom_range(0, 1)), $urandom_range(0, 4));
  endfunction

  function automatic instr_t mk_halt();
    instr_t t = mk(4'h0, 64'h0, 64'h0, 64'h0, 1'b0, 0);
    t.hlt = 1'b1;
    return t;
  endfunction

  function automatic instr_t mk_term();
    instr_t t = mk_rand();
    case ($urandom_range(0, 3))
      0: t = mk_halt();
      1: t.instr_valid = 1'b0;
      2: begin t.imm_err = 1'b1; t.instr_valid = 1'($urandom_range(0, 1)); t.hlt = 1'($urandom_range(0, 1)); end
      default: begin t.icode = 4'($urandom_range(8, 11)); t.dmem_err = 1'b1; end
    endcase
    return t;
  endfunction

  task automatic wait_for(input int sel, input string what, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if ((sel == 0 && mem_en) || (sel == 1 && wb_en) || (sel == 2 && !busy)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout_%s: no event within 400 cycles, expected one", what);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0; dmem_err = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pc", PC, 64'd0);
    check("rst_stat", 64'(stat), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_strobes", 64'(strobes), 64'd0);
    check("rst_retired", 64'(retired), 64'd0);
    check("rst_cycles", 64'(cycles), 64'd0);
    exp_q.delete();
    m_pc = 64'd0; m_ret = '0; m_cyc = '0;
    rst_n = 1'b1;
  endtask

  task automatic run_prog(input bit rst_mid);
    bit ok;
    do_reset();
    foreach (prog[i]) begin
      instr_t t = prog[i];
      exp_t   e;
      int     kind;
      model(t, e, kind);
      last_e = e;
      exp_q.push_back(e);
      icode = t.icode; valC = t.valC; valP = t.valP; cnd = t.cnd;
      instr_valid = t.instr_valid; imm_err = t.imm_err; hlt = t.hlt;
      valM = {$urandom, $urandom};
      start = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (kind == 1) begin
        wait_for(2, "halt_or_fault", ok);
        break;
      end
      if (is_mem(t.icode)) begin
        wait_for(0, "mem_en", ok);
        if (!ok) return;
        if (rst_mid) begin
          repeat (2) @(negedge clk);
          check("mid_mem_en_still_high", 64'(mem_en), 64'd1);
          rst_n = 1'b0;
          #1;
          check("mid_rst_pc", PC, 64'd0);
          check("mid_rst_stat", 64'(stat), 64'd1);
          check("mid_rst_busy", 64'(busy), 64'd0);
          check("mid_rst_strobes", 64'(strobes), 64'd0);
          check("mid_rst_counters", {retired, cycles}, 64'd0);
          exp_q.delete();
          return;
        end
        repeat (t.wait_n) @(negedge clk);
        mem_ready = 1'b1; valM = t.valM; dmem_err = t.dmem_err;
        @(negedge clk);
        mem_ready = 1'b0; dmem_err = 1'b0;
        if (kind == 2) begin
          wait_for(2, "dmem_fault", ok);
          break;
        end
      end else begin
        wait_for(1, "wb_en", ok);
        if (!ok) return;
      end
    end
    // terminal state must ignore start and hold PC, stat and counters
    repeat (4) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    check("frozen_busy", 64'(busy), 64'd0);
    check("frozen_pc", PC, last_e.pc);
    check("frozen_stat", 64'(stat), 64'(last_e.stat));
    check("frozen_retired", 64'(retired), 64'(last_e.retired));
    check("frozen_cycles", 64'(cycles), 64'(last_e.cycles));
  endtask

  initial begin : monitor
    exp_t cur;
    bit   active;
    int   lat, mc, wc;
    active = 1'b0; lat = 0; mc = 0; wc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) active = 1'b0;
      else begin
        if (busy) check("strobes_at_most_one", 64'($countones(strobes) > 1), 64'd0);
        else      check("strobes_when_idle", 64'(strobes), 64'd0);
        if (active && (fetch_en || !busy)) begin
          check("instr_cycles", 64'(lat), 64'(cur.lat));
          check("mem_en_cycles", 64'(mc), 64'(cur.mem_cyc));
          check("wb_en_cycles", 64'(wc), 64'(cur.wb_cyc));
          check("stat", 64'(stat), 64'(cur.stat));
          check("retired", 64'(retired), 64'(cur.retired));
          check("cycles", 64'(cycles), 64'(cur.cycles));
          if (!busy) check("stop_pc", PC, cur.pc);
          active = 1'b0;
        end
        if (fetch_en) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_fetch: fetch at PC 0x%0h, expected none", PC);
          end else begin
            cur = exp_q.pop_front();
            check("fetch_pc", PC, cur.pc);
            active = 1'b1; lat = 0; mc = 0; wc = 0;
          end
        end
        if (active) begin
          lat++;
          mc += int'(mem_en);
          wc += int'(wb_en);
        end
      end
    end
  end

  initial begin
    instr_t t;
    rst_n = 1'b0; start = 1'b0; icode = '0; instr_valid = 1'b1; imm_err = 1'b0; hlt = 1'b0;
    valC = '0; valP = '0; valM = '0; cnd = 1'b0; mem_ready = 1'b0; dmem_err = 1'b0;

    prog.delete();
    for (int i = 0; i < 3; i++) prog.push_back(mk(4'h1, 64'h0, 64'(i + 1), 64'h0, 1'b0, 0));
    prog.push_back(mk_halt());
    run_prog(1'b0);

    prog.delete();
    prog.push_back(mk(4'h7, 64'h100, 64'h9, 64'h0, 1'b1, 0));
    prog.push_back(mk(4'h7, 64'h55, 64'h20, 64'h0, 1'b0, 0));
    prog.push_back(mk_halt());
    run_prog(1'b0);

    prog.delete();
    prog.push_back(mk(4'h9, 64'h0, 64'h8, 64'h40, 1'b0, 3));
    prog.push_back(mk_halt());
    run_prog(1'b0);

    prog.delete();
    prog.push_back(mk(4'h8, 64'h10, 64'h9, 64'h0, 1'b0, 0));
    prog.push_back(mk_halt());
    run_prog(1'b0);

    prog.delete();
    t = mk(4'h1, 64'h0, 64'h1, 64'h0, 1'b0, 0); t.instr_valid = 1'b0;
    prog.push_back(t);
    run_prog(1'b0);

    prog.delete();
    t.imm_err = 1'b1;
    prog.push_back(t);
    run_prog(1'b0);

    prog.delete();
    t = mk(4'h5, 64'h0, 64'h1, 64'h77, 1'b0, 1); t.dmem_err = 1'b1;
    prog.push_back(t);
    run_prog(1'b0);

    prog.delete();
    prog.push_back(mk(4'h1, 64'h0, 64'h30, 64'h0, 1'b0, 0));
    prog.push_back(mk(4'h4, 64'h0, 64'h31, 64'h0, 1'b0, 10));
    run_prog(1'b1);

    for (int p = 0; p < 25; p++) begin
      prog.delete();
      for (int i = 0; i < $urandom_range(1, 8); i++) prog.push_back(mk_rand());
      prog.push_back(mk_term());
      run_prog(1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
